proc_ctrl: RTL
==============

# proc_ctrl

Multi-cycle fetch/decode/execute sequencer for the 8-bit datapath. It sits directly upstream of the `alu` combinational block: it drives the ALU select lines and operands and writes the ALU result back into a 4×8 register file. It also reads 14-bit instructions from a synchronous instruction ROM and exposes an output port and status flags.

## Interface
- No parameters; all widths are fixed.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `start` in 1: run request, sampled only in IDLE or HALTED.
- `instr_addr` out 8: ROM address (registered).
- `instr_data` in 14: ROM read data, valid the cycle after `instr_addr` changes.
- `alu_s1` out 1: ALU select 1, held 0 (reserved).
- `alu_s0` out 1: ALU select 0; 0 = pass `alu_a`, 1 = `alu_a + alu_b`.
- `alu_a` out 8: ALU operand 1.
- `alu_b` out 8: ALU operand 2.
- `alu_y` in 8: ALU result.
- `out_port` out 8: last value emitted by OUT.
- `out_valid` out 1: one-cycle pulse when `out_port` updates.
- `busy` out 1: high in FETCH, DECODE and EXEC.
- `halted` out 1: high in HALTED.

## Operation
- Instruction fields:
  - `[13:10]` opcode.
  - `[9:8]` rd.
  - `[7:6]` rs.
  - `[7:0]` imm; overlaps rs, used only by LDI and JNZ.
- Opcodes:
  - 0 NOP.
  - 1 LDI: `r[rd] <= imm`; ALU pass, `alu_a = imm`.
  - 2 MOV: `r[rd] <= r[rs]`; ALU pass, `alu_a = r[rs]`.
  - 3 ADD: `r[rd] <= r[rd] + r[rs]`; `alu_s0 = 1`, `alu_a = r[rd]`, `alu_b = r[rs]`.
  - 4 OUT: `out_port <= r[rd]`, `out_valid` pulse.
  - 5 JNZ: if `r[rd] != 0` then `pc <= imm`, else `pc <= pc + 1`.
  - 6 HALT.
  - 7–15 execute as NOP.
- All register writes take `alu_y`; the block never computes results itself. Arithmetic is modulo 256 and carry is discarded.
- States and transitions:
  - IDLE: if `start`, then `pc <= 0` and go to FETCH.
  - FETCH: `instr_addr <= pc`; go to DECODE.
  - DECODE: ROM data is valid; `ir <= instr_data`; go to EXEC.
  - EXEC: ALU driven from `ir` and the register file. At the end of the cycle, perform the write, the OUT capture and the pc update, then go to FETCH. HALT goes to HALTED instead, with pc unchanged.
  - HALTED: if `start`, then `pc <= 0` and go to FETCH. Register file and `out_port` are retained.
- Outside EXEC: `alu_s0 = 0`, `alu_a = 0`, `alu_b = 0`.
- pc is 8 bits and wraps 255 → 0 on increment; there is no fault.
- `start` is ignored while `busy`.
- `rd == rs` on ADD is legal and doubles the register.

## Timing
- 3 cycles per instruction, no pipelining.
- `start` sampled at edge k puts FETCH in cycle k+1. The first instruction's write lands at the end of cycle k+3.
- `out_valid` is registered: it is high for exactly the one cycle after the OUT instruction's EXEC (that is, the next FETCH), with `out_port` already updated.
- Write-after-write in consecutive instructions is safe: the write completes before the next DECODE.
- Reset (any time, including mid-instruction):
  - State IDLE; pc 0; ir 0.
  - r0–r3 = 0.
  - `instr_addr` 0, `out_port` 0.
  - `out_valid`, `busy`, `halted`, `alu_s1`, `alu_s0` all 0; `alu_a` and `alu_b` 0.
- Release of `rst_n` takes effect at the next edge; no instruction completes partially.

## Test plan
- Reset then idle: all outputs 0; `start` low for 10 cycles → `instr_addr` stays 0 and `busy` stays 0.
- Program LDI r0,5; LDI r1,7; ADD r0,r1; OUT r0; HALT → `out_valid` pulse with `out_port = 12` in cycle k+13; `halted = 1` from k+16 on.
- Overflow: LDI r2,200; LDI r3,100; ADD r2,r3; OUT r2 → `out_port = 44`, with `alu_s0 = 1` and `alu_a = 200`, `alu_b = 100` during ADD's EXEC.
- Loop: LDI r0,3; LDI r1,255; [2] ADD r0,r1; OUT r0; JNZ r0,2; HALT → `out_port` sequence 2, 1, 0, then HALTED.
- Reset asserted during EXEC of ADD r0,r1 → r0 = 0 and state IDLE immediately; `busy` falls without waiting for a clock edge.
- `start` pulsed while `busy` → no effect. `start` in HALTED → `instr_addr` returns to 0 and a program of 256 NOPs wraps pc 255 → 0 with `busy` held high.

Source files
------------

// File: rtl/proc_ctrl.sv
// proc_ctrl: multi-cycle fetch/decode/execute sequencer that drives an external 8-bit ALU
// Ports: clk, rst_n (async active-low); start run request;
//   instr_addr/instr_data instruction ROM address and read data;
//   alu_s1/alu_s0/alu_a/alu_b ALU select and operands, alu_y ALU result;
//   out_port/out_valid OUT data and update pulse; busy/halted status.
module proc_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  instr_addr,
  input  logic [13:0] instr_data,
  output logic        alu_s1,
  output logic        alu_s0,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_y,
  output logic [7:0]  out_port,
  output logic        out_valid,
  output logic        busy,
  output logic        halted
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALTED} state_t;
  localparam logic [3:0] OP_LDI = 4'd1, OP_MOV = 4'd2, OP_ADD = 4'd3, OP_OUT = 4'd4, OP_JNZ = 4'd5, OP_HALT = 4'd6;
  state_t state_q, state_d;
  logic [7:0] pc_q, pc_d, addr_q, addr_d, out_q, out_d;
  logic [13:0] ir_q, ir_d;
  logic [3:0][7:0] rf_q, rf_d;
  logic ov_q, ov_d;
  logic [3:0] op;
  logic [1:0] rd, rs;
  logic [7:0] imm;
  logic exec;
  // rs and imm deliberately overlap; each opcode uses only the field it needs
  assign op = ir_q[13:10];
  assign rd = ir_q[9:8];
  assign rs = ir_q[7:6];
  assign imm = ir_q[7:0];
  assign exec = state_q == EXEC;
  // ALU drive kept apart from next-state logic so alu_y -> rf_d has no loop through one block
  assign alu_s1 = 1'b0;
  assign alu_s0 = exec && op == OP_ADD;
  assign alu_a = !exec ? 8'd0 : op == OP_LDI ? imm : op == OP_MOV ? rf_q[rs] : op == OP_ADD ? rf_q[rd] : 8'd0;
  assign alu_b = alu_s0 ? rf_q[rs] : 8'd0;
  assign instr_addr = addr_q;
  assign out_port = out_q;
  assign out_valid = ov_q;
  assign busy = state_q inside {FETCH, DECODE, EXEC};
  assign halted = state_q == HALTED;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    addr_d = addr_q;
    ir_d = ir_q;
    rf_d = rf_q;
    out_d = out_q;
    ov_d = 1'b0;
    case (state_q)
      IDLE, HALTED: begin
        pc_d = start ? 8'd0 : pc_q;
        state_d = start ? FETCH : state_q;
      end
      FETCH: begin
        addr_d = pc_q;
        state_d = DECODE;
      end
      DECODE: begin
        ir_d = instr_data;
        state_d = EXEC;
      end
      EXEC: begin
        if (op inside {OP_LDI, OP_MOV, OP_ADD}) rf_d[rd] = alu_y;
        out_d = op == OP_OUT ? rf_q[rd] : out_q;
        ov_d = op == OP_OUT;
        pc_d = (op == OP_JNZ && rf_q[rd] != 8'd0) ? imm : op == OP_HALT ? pc_q : pc_q + 8'd1;
        state_d = op == OP_HALT ? HALTED : FETCH;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q <= '0;
      addr_q <= '0;
      ir_q <= '0;
      rf_q <= '0;
      out_q <= '0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      addr_q <= addr_d;
      ir_q <= ir_d;
      rf_q <= rf_d;
      out_q <= out_d;
      ov_q <= ov_d;
    end
  end
endmodule
